modulo_sel_coord: RTL and testbench
===================================

Name: modulo_sel_coord

Overview:
- Upstream stage of the line-coordinate decode: turns the player's raw push-button presses into the 3-bit line selection `mdl` and 3-bit column selection `mdc` that feed the coordinate-decode stages.
- Synchronises and debounces three buttons and keeps a line/column cursor.
- On confirm, presents the chosen coordinate to the game logic with a valid/ack handshake.

Parameters:
- N_LINHAS, 7, number of selectable lines; cursor line range 0..N_LINHAS-1 (max 8).
- N_COLUNAS, 5, number of selectable columns; range 0..N_COLUNAS-1 (max 8).
- DEB_CYCLES, 16, consecutive stable samples needed to accept a button level change (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_linha_n  in  1  raw button, active-low, asynchronous: advance line.
- btn_coluna_n  in  1  raw button, active-low, asynchronous: advance column.
- btn_conf_n  in  1  raw button, active-low, asynchronous: confirm coordinate.
- coord_ack  in  1  downstream accepted the coordinate.
- mdl  out  3  current line cursor, drives line-coordinate decode.
- mdc  out  3  current column cursor.
- coord_valid  out  1  confirmed coordinate pending.
- busy  out  1  high in HOLD; buttons ignored.

Behaviour:
- Reset (async, active-high): mdl=0, mdc=0, coord_valid=0, busy=0, FSM=SEL, debounce counters=0, debounced levels=released.
- Input path, per button:
  - 2-flop synchroniser.
  - Debounce counter: increments while the synced level differs from the debounced level and resets to 0 when they match. When it reaches DEB_CYCLES-1, the debounced level flips.
  - Press edge: released->pressed transition of the debounced level gives a 1-cycle pulse (p_lin, p_col, p_conf).
  - Holding a button produces exactly one pulse; the release produces none.
- Latency: a clean press stable from cycle 0 gives its pulse in cycle 2+DEB_CYCLES; the cursor/valid update becomes visible after the following rising edge.
- Glitches shorter than DEB_CYCLES samples: no pulse.
- FSM SEL:
  - p_lin: mdl advances by 1. p_col: mdc advances by 1.
  - p_lin and p_col in the same cycle: both advance.
  - p_conf: FSM goes to HOLD, coord_valid=1, busy=1 next cycle. Any p_lin/p_col in that same cycle is dropped (confirm wins).
- FSM HOLD:
  - mdl/mdc frozen; all button pulses discarded (not queued).
  - coord_valid stays 1 until coord_ack=1 is sampled in HOLD. Then next cycle: coord_valid=0, busy=0, FSM=SEL.
  - coord_ack while in SEL is ignored.
  - mdl/mdc retain their values after ack, so the cursor stays on the last coordinate.
- Cursor arithmetic: 3-bit unsigned; the value at max (N-1) follows the Optional Feature rule.
- Reset mid-HOLD: immediately returns to the reset state; the pending coordinate is lost and coord_valid drops asynchronously.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro COORD_WRAP_EN.
- Defined: advancing from N-1 wraps to 0 (line 6->0 with defaults; column 4->0).
- Undefined: saturates at N-1; further presses leave the value unchanged.
- Identical behaviour for line and column.

Decomposition:
- Shared package (`pkg_coord`):
  - FSM state encoding (SEL=1'b0, HOLD=1'b1).
  - Coordinate width constant COORD_W=3.
  - Default N_LINHAS/N_COLUNAS shared with the line/column decode stages.
- One natural sub-module, `modulo_debounce` (synchroniser + counter + edge pulse, parameter DEB_CYCLES), instantiated three times.
- Cursor counters and FSM live in the top module.

Test Plan:
- Reset, then 3 clean line presses (DEB_CYCLES=4) -> mdl=3, mdc=0, coord_valid=0.
- 1-cycle and 3-cycle low glitches on btn_linha_n (DEB_CYCLES=4) -> no pulse, mdl unchanged.
- Hold btn_coluna_n low for 100 cycles -> mdc increments exactly once.
- 7 line presses from 0:
  - with COORD_WRAP_EN -> mdl=0;
  - without -> mdl=6 after press 6 and stays 6.
- Cursor (2,1), press confirm -> coord_valid=1, busy=1. Then press line twice while ack=0 -> mdl stays 2. Pulse ack -> coord_valid=0 next cycle, mdl=2, mdc=1.
- Confirm and line pulses in the same cycle -> HOLD entered, mdl unchanged. Assert rst mid-HOLD -> coord_valid=0, mdl=0, mdc=0 immediately.

Source files
------------

// File: rtl/pkg_coord.sv
// Shared definitions for the coordinate selection and decode stages.
// Holds the FSM encoding, coordinate width and default board dimensions.
package pkg_coord;

  localparam int unsigned COORD_W = 3;

  localparam int unsigned N_LINHAS_DEF  = 7;
  localparam int unsigned N_COLUNAS_DEF = 5;

  typedef enum logic {
    StSel  = 1'b0,
    StHold = 1'b1
  } coord_state_e;

  // Advance a cursor by one, either wrapping to 0 or saturating at vmax.
  function automatic logic [COORD_W-1:0] coord_next(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] vmax,
                                                    input logic               wrap);
    logic [COORD_W-1:0] r;
    if (v >= vmax) begin
      r = wrap ? '0 : vmax;
    end else begin
      r = v + COORD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/modulo_debounce.sv
// One push button: 2-flop synchroniser, stability counter and press-edge pulse.
// The raw input is active-low; the pulse fires once per accepted press.
module modulo_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pulse
);

  localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic            deb_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], btn_n};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // The DEB_CYCLES-th consecutive differing sample flips the debounced level.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign pulse = deb_prev_q & ~deb_q;

endmodule

// File: rtl/modulo_sel_coord.sv
// Line/column cursor selection with debounced buttons and a valid/ack confirm handshake.
// Define COORD_WRAP_EN to wrap cursors at N-1 back to 0; otherwise they saturate.
module modulo_sel_coord
  import pkg_coord::*;
#(
  parameter int unsigned N_LINHAS   = N_LINHAS_DEF,
  parameter int unsigned N_COLUNAS  = N_COLUNAS_DEF,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_linha_n,
  input  logic               btn_coluna_n,
  input  logic               btn_conf_n,
  input  logic               coord_ack,
  output logic [COORD_W-1:0] mdl,
  output logic [COORD_W-1:0] mdc,
  output logic               coord_valid,
  output logic               busy
);

`ifdef COORD_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  localparam logic [COORD_W-1:0] LinMax = COORD_W'(N_LINHAS - 1);
  localparam logic [COORD_W-1:0] ColMax = COORD_W'(N_COLUNAS - 1);

  logic p_lin, p_col, p_conf;

  modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lin (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_linha_n),
    .pulse (p_lin)
  );

  modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_col (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_coluna_n),
    .pulse (p_col)
  );

  modulo_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_conf (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_conf_n),
    .pulse (p_conf)
  );

  coord_state_e       state_q, state_d;
  logic [COORD_W-1:0] mdl_q, mdl_d;
  logic [COORD_W-1:0] mdc_q, mdc_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSel;
      mdl_q   <= '0;
      mdc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdl_q   <= mdl_d;
      mdc_q   <= mdc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mdl_d   = mdl_q;
    mdc_d   = mdc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      StSel: begin
        // Confirm takes priority; cursor moves in the same cycle are dropped.
        if (p_conf) begin
          state_d = StHold;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          if (p_lin) mdl_d = coord_next(mdl_q, LinMax, WrapEn);
          if (p_col) mdc_d = coord_next(mdc_q, ColMax, WrapEn);
        end
      end
      StHold: begin
        if (coord_ack) begin
          state_d = StSel;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StSel;
      end
    endcase
  end

  assign mdl         = mdl_q;
  assign mdc         = mdc_q;
  assign coord_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_modulo_sel_coord.sv
// Directed bench for modulo_sel_coord with DEB_CYCLES=4; expectations follow COORD_WRAP_EN.
module tb_modulo_sel_coord;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_linha_n = 1'b1;
  logic       btn_coluna_n = 1'b1;
  logic       btn_conf_n = 1'b1;
  logic       coord_ack = 1'b0;
  logic [2:0] mdl, mdc;
  logic       coord_valid, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modulo_sel_coord #(.DEB_CYCLES(Deb)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_linha_n  (btn_linha_n),
    .btn_coluna_n (btn_coluna_n),
    .btn_conf_n   (btn_conf_n),
    .coord_ack    (coord_ack),
    .mdl          (mdl),
    .mdc          (mdc),
    .coord_valid  (coord_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  // sel: 0 line, 1 column, 2 confirm, 3 line+confirm together
  task automatic press(input int sel, input int hold);
    @(negedge clk);
    case (sel)
      0: btn_linha_n = 1'b0;
      1: btn_coluna_n = 1'b0;
      2: btn_conf_n = 1'b0;
      default: begin
        btn_linha_n = 1'b0;
        btn_conf_n = 1'b0;
      end
    endcase
    cycles(hold);
    btn_linha_n = 1'b1;
    btn_coluna_n = 1'b1;
    btn_conf_n = 1'b1;
    cycles(Deb + 6);
  endtask

  initial begin
    do_reset();
    check("rst_mdl", mdl, 0);
    check("rst_mdc", mdc, 0);
    check("rst_valid", coord_valid, 0);
    check("rst_busy", busy, 0);

    // Exact latency: pulse in cycle 2+Deb, cursor visible after the next edge.
    @(negedge clk);
    btn_linha_n = 1'b0;
    cycles(2 + Deb);
    check("lat_before", mdl, 0);
    cycles(1);
    check("lat_after", mdl, 1);
    cycles(4);
    btn_linha_n = 1'b1;
    cycles(Deb + 6);
    check("release_no_pulse", mdl, 1);

    press(0, Deb + 6);
    press(0, Deb + 6);
    check("three_lin_mdl", mdl, 3);
    check("three_lin_mdc", mdc, 0);
    check("three_lin_valid", coord_valid, 0);

    press(0, 1);
    check("glitch1", mdl, 3);
    press(0, 3);
    check("glitch3", mdl, 3);
    press(0, Deb);
    check("min_press", mdl, 4);

    press(1, 100);
    check("hold_col", mdc, 1);

    // Seven line presses from zero.
    do_reset();
    for (int i = 0; i < 6; i++) press(0, Deb + 4);
    check("lin6", mdl, 6);
    press(0, Deb + 4);
`ifdef COORD_WRAP_EN
    check("lin7_wrap", mdl, 0);
`else
    check("lin7_sat", mdl, 6);
    press(0, Deb + 4);
    check("lin8_sat", mdl, 6);
`endif

    // Confirm handshake at cursor (2,1).
    do_reset();
    press(0, Deb + 4);
    press(0, Deb + 4);
    press(1, Deb + 4);
    @(negedge clk);
    coord_ack = 1'b1;
    cycles(2);
    coord_ack = 1'b0;
    check("ack_in_sel_valid", coord_valid, 0);
    check("ack_in_sel_mdl", mdl, 2);
    press(2, Deb + 4);
    check("conf_valid", coord_valid, 1);
    check("conf_busy", busy, 1);
    press(0, Deb + 4);
    press(0, Deb + 4);
    press(1, Deb + 4);
    check("hold_mdl", mdl, 2);
    check("hold_mdc", mdc, 1);
    check("hold_valid", coord_valid, 1);
    @(negedge clk);
    coord_ack = 1'b1;
    @(negedge clk);
    coord_ack = 1'b0;
    check("ack_valid", coord_valid, 0);
    check("ack_busy", busy, 0);
    cycles(10);
    check("ack_mdl", mdl, 2);
    check("ack_mdc", mdc, 1);
    press(0, Deb + 4);
    check("sel_again", mdl, 3);

    // Confirm wins over a simultaneous line press, then async reset mid-hold.
    do_reset();
    press(0, Deb + 4);
    press(1, Deb + 4);
    press(3, Deb + 4);
    check("sim_valid", coord_valid, 1);
    check("sim_mdl", mdl, 1);
    check("sim_mdc", mdc, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", coord_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_mdl", mdl, 0);
    check("arst_mdc", mdc, 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    check("post_rst_valid", coord_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
